// File: rtl/axi_master_pkg.sv
// Shared types and constants for the core-to-AXI4 master port.
// Bus widths mirror the values in AXI_define.svh so every importer agrees on them.
package axi_master_pkg;

   localparam int AXI_ID_BITS   = 4;
   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_STRB_BITS = 4;
   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_SIZE_BITS = 3;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AW   = 3'd3,
      S_W    = 3'd4,
      S_B    = 3'd5,
      S_RESP = 3'd6
   } state_e;

   typedef struct packed {
      logic                     write;
      logic [AXI_ADDR_BITS-1:0] addr;
      logic [AXI_LEN_BITS-1:0]  len;
      logic [AXI_SIZE_BITS-1:0] size;
   } req_t;

endpackage

// File: rtl/axi_master_if.sv
// Core request port to AXI4 master: one outstanding INCR burst (1..16 beats), read or write,
// each closed by a single OKAY/SLVERR status back to the core.
module axi_master_if
   import axi_master_pkg::*;
#(
   parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [AXI_ADDR_BITS-1:0] req_addr,
   input  logic [AXI_LEN_BITS-1:0]  req_len,
   input  logic [AXI_SIZE_BITS-1:0] req_size,
   input  logic [AXI_DATA_BITS-1:0] wr_data,
   input  logic [AXI_STRB_BITS-1:0] wr_strb,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [AXI_DATA_BITS-1:0] rd_data,
   output logic                     rd_last,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic                     resp_valid,
   output logic [1:0]               resp_code,
   input  logic                     resp_ready,
   output logic [AXI_ID_BITS-1:0]   AWID,
   output logic [AXI_ADDR_BITS-1:0] AWADDR,
   output logic [AXI_LEN_BITS-1:0]  AWLEN,
   output logic [AXI_SIZE_BITS-1:0] AWSIZE,
   output logic [1:0]               AWBURST,
   output logic                     AWVALID,
   input  logic                     AWREADY,
   output logic [AXI_DATA_BITS-1:0] WDATA,
   output logic [AXI_STRB_BITS-1:0] WSTRB,
   output logic                     WLAST,
   output logic                     WVALID,
   input  logic                     WREADY,
   input  logic [AXI_ID_BITS-1:0]   BID,
   input  logic [1:0]               BRESP,
   input  logic                     BVALID,
   output logic                     BREADY,
   output logic [AXI_ID_BITS-1:0]   ARID,
   output logic [AXI_ADDR_BITS-1:0] ARADDR,
   output logic [AXI_LEN_BITS-1:0]  ARLEN,
   output logic [AXI_SIZE_BITS-1:0] ARSIZE,
   output logic [1:0]               ARBURST,
   output logic                     ARVALID,
   input  logic                     ARREADY,
   input  logic [AXI_ID_BITS-1:0]   RID,
   input  logic [AXI_DATA_BITS-1:0] RDATA,
   input  logic [1:0]               RRESP,
   input  logic                     RLAST,
   input  logic                     RVALID,
   output logic                     RREADY
);

   state_e                  state_q;
   req_t                    req_q;
   logic [AXI_LEN_BITS-1:0] cnt_q;
   logic                    err_q;

   logic ax_vld, ar_vld, aw_vld, in_r, in_w, in_b, in_resp;
   logic r_hs, w_hs, at_len, r_err_d, b_err_d;

   assign ax_vld  = (state_q == S_AR) || (state_q == S_AW);
   assign ar_vld  = ax_vld && !req_q.write;
   assign aw_vld  = ax_vld &&  req_q.write;
   assign in_r    = (state_q == S_R);
   assign in_w    = (state_q == S_W);
   assign in_b    = (state_q == S_B);
   assign in_resp = (state_q == S_RESP);

   assign at_len = (cnt_q == req_q.len);
   assign r_hs   = in_r && RVALID && rd_ready;
   assign w_hs   = in_w && wr_valid && WREADY;
   // A beat is bad if the slave's RLAST and our own beat count disagree in either direction.
   assign r_err_d = (RRESP != RESP_OKAY) || (RID != MASTER_ID) || (RLAST != at_len);
   assign b_err_d = (BRESP != RESP_OKAY) || (BID != MASTER_ID);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid) begin
               req_q   <= '{write: req_write, addr: req_addr, len: req_len, size: req_size};
               cnt_q   <= '0;
               err_q   <= 1'b0;
               state_q <= req_write ? S_AW : S_AR;
            end
            S_AR: if (ARREADY) state_q <= S_R;
            S_R: if (r_hs) begin
               cnt_q <= cnt_q + 1'b1;
               if (r_err_d) err_q <= 1'b1;
               if (at_len || RLAST) state_q <= S_RESP;
            end
            S_AW: if (AWREADY) state_q <= S_W;
            S_W: if (w_hs) begin
               cnt_q <= cnt_q + 1'b1;
               if (at_len) state_q <= S_B;
            end
            S_B: if (BVALID) begin
               if (b_err_d) err_q <= 1'b1;
               state_q <= S_RESP;
            end
            S_RESP: if (resp_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = in_resp;
   assign resp_code  = (in_resp && err_q) ? RESP_SLVERR : RESP_OKAY;

   assign ARVALID = ar_vld;
   assign ARID    = ar_vld ? MASTER_ID : '0;
   assign ARADDR  = req_q.addr;
   assign ARLEN   = req_q.len;
   assign ARSIZE  = req_q.size;
   assign ARBURST = ar_vld ? BURST_INCR : 2'b00;

   assign AWVALID = aw_vld;
   assign AWID    = aw_vld ? MASTER_ID : '0;
   assign AWADDR  = req_q.addr;
   assign AWLEN   = req_q.len;
   assign AWSIZE  = req_q.size;
   assign AWBURST = aw_vld ? BURST_INCR : 2'b00;

   // Data channels pass straight through, but only while their phase is active.
   assign RREADY   = in_r && rd_ready;
   assign rd_valid = in_r && RVALID;
   assign rd_data  = in_r ? RDATA : '0;
   assign rd_last  = in_r && RLAST;

   assign WVALID   = in_w && wr_valid;
   assign wr_ready = in_w && WREADY;
   assign WDATA    = in_w ? wr_data : '0;
   assign WSTRB    = in_w ? wr_strb : '0;
   assign WLAST    = in_w && at_len;

   assign BREADY = in_b;

endmodule

// File: tb/tb_axi_master_if.sv
// Directed bench for axi_master_if: the bench plays both the core and the AXI slave.
// Inputs change at the falling edge; outputs are checked 1 time unit later.
module tb_axi_master_if;
   import axi_master_pkg::*;

   logic                     ACLK = 1'b0;
   logic                     ARESET;
   logic                     req_valid, req_ready, req_write;
   logic [AXI_ADDR_BITS-1:0] req_addr;
   logic [AXI_LEN_BITS-1:0]  req_len;
   logic [AXI_SIZE_BITS-1:0] req_size;
   logic [AXI_DATA_BITS-1:0] wr_data, rd_data;
   logic [AXI_STRB_BITS-1:0] wr_strb;
   logic                     wr_valid, wr_ready, rd_last, rd_valid, rd_ready;
   logic                     resp_valid, resp_ready;
   logic [1:0]               resp_code;
   logic [AXI_ID_BITS-1:0]   AWID, BID, ARID, RID;
   logic [AXI_ADDR_BITS-1:0] AWADDR, ARADDR;
   logic [AXI_LEN_BITS-1:0]  AWLEN, ARLEN;
   logic [AXI_SIZE_BITS-1:0] AWSIZE, ARSIZE;
   logic [1:0]               AWBURST, ARBURST, BRESP, RRESP;
   logic                     AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic                     ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [AXI_DATA_BITS-1:0] WDATA, RDATA;
   logic [AXI_STRB_BITS-1:0] WSTRB;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 ACLK = ~ACLK;

   axi_master_if #(.MASTER_ID(4'd0)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .resp_valid(resp_valid), .resp_code(resp_code), .resp_ready(resp_ready),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge ACLK);
   endtask

   task automatic issue_req(input logic w, input logic [31:0] addr, input logic [3:0] len);
      req_valid = 1'b1; req_write = w; req_addr = addr; req_len = len; req_size = 3'd2;
      #1 chk("req_ready_idle", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic ar_phase(input logic [31:0] addr, input logic [3:0] len);
      #1;
      chk("arvalid", 32'(ARVALID), 1);
      chk("araddr", ARADDR, addr);
      chk("arlen", 32'(ARLEN), 32'(len));
      chk("arburst", 32'(ARBURST), 1);
      chk("req_ready_busy", 32'(req_ready), 0);
      ARREADY = 1'b1;
      tick();
      ARREADY = 1'b0;
   endtask

   task automatic rbeat(input logic [31:0] data, input logic last, input logic [1:0] rr, input string tag);
      RVALID = 1'b1; RDATA = data; RLAST = last; RRESP = rr; RID = 4'd0; rd_ready = 1'b1;
      #1;
      chk({tag, "_rd_data"}, rd_data, data);
      chk({tag, "_rd_last"}, 32'(rd_last), 32'(last));
      chk({tag, "_rready"}, 32'(RREADY), 1);
      tick();
      RVALID = 1'b0; RLAST = 1'b0;
   endtask

   task automatic resp_phase(input logic [1:0] code, input string tag);
      #1;
      chk({tag, "_resp_valid"}, 32'(resp_valid), 1);
      chk({tag, "_resp_code"}, 32'(resp_code), 32'(code));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      #1;
      chk({tag, "_resp_done"}, 32'(resp_valid), 0);
      chk({tag, "_back_idle"}, 32'(req_ready), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESET = 1'b1;
      req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_size = 0;
      wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0; resp_ready = 0;
      AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0; ARREADY = 0;
      RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;

      tick();
      #1;
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_arvalid", 32'(ARVALID), 0);
      chk("rst_awvalid", 32'(AWVALID), 0);
      chk("rst_bready", 32'(BREADY), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_araddr", ARADDR, 0);
      ARESET = 1'b0;
      tick();

      // Single read
      issue_req(1'b0, 32'h10, 4'd0);
      ar_phase(32'h10, 4'd0);
      #1 chk("single_arvalid_drop", 32'(ARVALID), 0);
      rbeat(32'hDEADBEEF, 1'b1, RESP_OKAY, "single");
      resp_phase(RESP_OKAY, "single");

      // Burst read, core stalls the first beat for two cycles
      issue_req(1'b0, 32'h100, 4'd3);
      ar_phase(32'h100, 4'd3);
      RVALID = 1'b1; RDATA = 32'h1000; RLAST = 1'b0; rd_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("burst_stall_rready", 32'(RREADY), 0);
         chk("burst_stall_rd_valid", 32'(rd_valid), 1);
         tick();
      end
      for (int i = 0; i < 4; i++) rbeat(32'h1000 + 32'(i), (i == 3), RESP_OKAY, "burst");
      rd_ready = 1'b0;
      resp_phase(RESP_OKAY, "burst");

      // Write with WREADY stalled for three cycles
      issue_req(1'b1, 32'h20, 4'd1);
      #1;
      chk("wr_awvalid", 32'(AWVALID), 1);
      chk("wr_awaddr", AWADDR, 32'h20);
      chk("wr_awlen", 32'(AWLEN), 1);
      chk("wr_awburst", 32'(AWBURST), 1);
      AWREADY = 1'b1;
      tick();
      AWREADY = 1'b0;
      wr_valid = 1'b1; wr_data = 32'hA5A5_0001; wr_strb = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wr_stall_wvalid", 32'(WVALID), 1);
         chk("wr_stall_wdata", WDATA, 32'hA5A5_0001);
         chk("wr_stall_wlast", 32'(WLAST), 0);
         chk("wr_stall_wr_ready", 32'(wr_ready), 0);
         tick();
      end
      WREADY = 1'b1;
      #1;
      chk("wr_b1_wr_ready", 32'(wr_ready), 1);
      chk("wr_b1_wstrb", 32'(WSTRB), 32'h3);
      tick();
      wr_data = 32'hA5A5_0002;
      #1;
      chk("wr_b2_wlast", 32'(WLAST), 1);
      chk("wr_b2_wdata", WDATA, 32'hA5A5_0002);
      tick();
      // Core keeps offering a third beat; it must be refused now that the burst is done
      wr_data = 32'hA5A5_0003;
      #1;
      chk("wr_b_bready", 32'(BREADY), 1);
      chk("wr_extra_wr_ready", 32'(wr_ready), 0);
      chk("wr_extra_wvalid", 32'(WVALID), 0);
      wr_valid = 1'b0; WREADY = 1'b0;
      BVALID = 1'b1; BRESP = RESP_OKAY; BID = 4'd0;
      tick();
      BVALID = 1'b0;
      resp_phase(RESP_OKAY, "wr");

      // Early RLAST on beat 2 of a 4-beat read
      issue_req(1'b0, 32'h200, 4'd3);
      ar_phase(32'h200, 4'd3);
      rbeat(32'h2000, 1'b0, RESP_OKAY, "early");
      rbeat(32'h2001, 1'b1, RESP_OKAY, "early");
      rd_ready = 1'b0;
      resp_phase(RESP_SLVERR, "early");

      // AWREADY already high; slave answers BRESP=SLVERR
      AWREADY = 1'b1;
      issue_req(1'b1, 32'h40, 4'd0);
      #1 chk("fast_awvalid", 32'(AWVALID), 1);
      tick();
      AWREADY = 1'b0;
      wr_valid = 1'b1; wr_data = 32'h0BAD_F00D; wr_strb = 4'hF; WREADY = 1'b1;
      #1;
      chk("fast_in_w_wvalid", 32'(WVALID), 1);
      chk("fast_in_w_wlast", 32'(WLAST), 1);
      tick();
      wr_valid = 1'b0; WREADY = 1'b0;
      BVALID = 1'b1; BRESP = RESP_SLVERR;
      #1 chk("bresp_bready", 32'(BREADY), 1);
      tick();
      BVALID = 1'b0; BRESP = RESP_OKAY;
      resp_phase(RESP_SLVERR, "bresp");

      // Reset asserted while the slave presents beat 2 of a burst read
      issue_req(1'b0, 32'h300, 4'd3);
      ar_phase(32'h300, 4'd3);
      rbeat(32'h3000, 1'b0, RESP_OKAY, "abort");
      RVALID = 1'b1; RDATA = 32'h3001; rd_ready = 1'b1;
      ARESET = 1'b1;
      #1;
      chk("abort_rready", 32'(RREADY), 0);
      chk("abort_rd_valid", 32'(rd_valid), 0);
      chk("abort_rd_data", rd_data, 0);
      chk("abort_req_ready", 32'(req_ready), 1);
      chk("abort_resp_valid", 32'(resp_valid), 0);
      chk("abort_araddr", ARADDR, 0);
      tick();
      ARESET = 1'b0; RVALID = 1'b0;
      tick();
      issue_req(1'b0, 32'h44, 4'd0);
      ar_phase(32'h44, 4'd0);
      rbeat(32'hCAFE_0044, 1'b1, RESP_OKAY, "after_rst");
      resp_phase(RESP_OKAY, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_master_if.md
Name: axi_master_if

Overview:
- AXI4 master port that converts a simple core-side memory request (single or INCR burst, up to 16 beats) into AR/R or AW/W/B transactions.
- Sits between a CPU/DMA core port and the AXI interconnect, opposite the SRAM slave wrappers.
- Reads stream beat-by-beat back to the core; writes stream beat-by-beat from the core.
- Each transaction ends with one status response to the core.

Parameters:
- MASTER_ID, 4'd0: value driven on ARID/AWID; expected on RID/BID.
- Address, data, strobe, length and size widths come from AXI_define.svh and are not parameters.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  core request accepted (high only in IDLE)
req_write  in  1  1=write, 0=read
req_addr  in  AXI_ADDR_BITS  start address
req_len  in  AXI_LEN_BITS  beats-1 (0..15)
req_size  in  AXI_SIZE_BITS  bytes per beat = 1<<size
wr_data  in  AXI_DATA_BITS  write beat data
wr_strb  in  AXI_STRB_BITS  write beat strobes
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted
rd_data  out  AXI_DATA_BITS  read beat data
rd_last  out  1  final read beat
rd_valid  out  1  read beat valid
rd_ready  in  1  core accepts read beat
resp_valid  out  1  transaction done
resp_code  out  2  OKAY/SLVERR (AXI_RESP encoding)
resp_ready  in  1  core accepts status
AW*/W*/B*/AR*/R* master-side AXI signals: the full standard set (ID, ADDR, LEN, SIZE, BURST, VALID/READY, DATA, STRB, LAST, RESP), widths per AXI_define.svh.

Behaviour:
- Reset: asynchronous on ARESET high. State=IDLE, latched request and counter=0, error flag cleared. Every output is 0 except req_ready=1, since it is combinational from IDLE. Reset mid-burst abandons the transaction; no further beats are issued.
- States: IDLE, AR, R, AW, W, B, RESP.
- IDLE: req_ready=1. On req_valid, latch {write, addr, len, size}, clear counter and err, then go to AW if write, else AR. No zero-cycle passthrough: ARVALID/AWVALID assert the cycle after acceptance.
- AR / AW: drive VALID with the latched ID/ADDR/LEN/SIZE and BURST=2'b01 (INCR). Fields are held stable until READY. ARREADY → R; AWREADY → W. READY arriving in the same cycle VALID rises counts as the handshake.
- R: RREADY=rd_ready; rd_valid=RVALID; rd_data=RDATA; rd_last=RLAST; all combinational pass-through.
  - Each handshake increments the 4-bit counter.
  - Set err if RRESP!=OKAY, RID!=MASTER_ID, RLAST with counter!=len, or counter==len without RLAST.
  - Handshake with counter==len, or with RLAST, → RESP.
- W: WVALID=wr_valid; wr_ready=WREADY; WDATA/WSTRB pass-through; WLAST=(counter==len).
  - Handshake increments the counter. Handshake with WLAST → B.
  - The core must not present more than len+1 beats; extra beats are ignored (wr_ready=0 outside W).
- B: BREADY=1. On BVALID, set err if BRESP!=OKAY or BID!=MASTER_ID, then → RESP.
- RESP: resp_valid=1; resp_code = err ? SLVERR(2'b10) : OKAY. On resp_ready → IDLE. A new request is accepted no earlier than the following cycle.
- Counter wraps modulo 16; len=15 yields exactly 16 beats.
- Masters never interleave: one outstanding transaction, reads and writes serialized.

Decomposition:
- Package axi_master_pkg holds:
  - state enum (3-bit)
  - request struct {write, addr, len, size}
  - constants BURST_INCR=2'b01 and the response codes, re-exported from AXI_define.svh
- No sub-module is needed; counter and error logic stay inline.

Test Plan:
- Single read: req addr=0x0000_0010, len=0, size=2; slave returns RDATA=0xDEADBEEF, RLAST=1 → ARADDR=0x10, ARLEN=0, ARBURST=01; rd_data=0xDEADBEEF, rd_last=1; resp_code=OKAY.
- Burst read: len=3, rd_ready low for 2 cycles on beat 1 → RREADY follows rd_ready; 4 beats delivered in order; rd_last only on beat 4; one resp_valid.
- Write with stall: addr=0x20, len=1, strb=4'b0011; WREADY low for 3 cycles → WVALID/WDATA held; WLAST=1 only on beat 2; BREADY=1; resp OKAY.
- Error: slave asserts RLAST on beat 2 of a len=3 read → transaction ends at that beat; resp_code=2'b10. Separately, BRESP=SLVERR → resp_code=2'b10.
- AWREADY already high when AWVALID rises → handshake in 1 cycle; W entered the next cycle.
- ARESET pulsed mid-read-burst (beat 2) → all outputs 0 immediately, req_ready=1; a new read afterwards completes normally.
